// File: rtl/alu_issue_sched_if.sv
// Signal bundle between the issue lanes, the shared ALU and writeback for alu_issue_sched.
// The scheduler connects through the slave modport; the surrounding pipeline uses master.
interface alu_issue_sched_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*ADDR_W-1:0] req_dest;
    logic [2*OP_W-1:0]   req_op;
    logic [1:0]          req_type;
    logic [2*DATA_W-1:0] req_d1;
    logic [2*DATA_W-1:0] req_d2;

    logic                alu_call;
    logic [ADDR_W-1:0]   alu_dest;
    logic [OP_W-1:0]     alu_op;
    logic                alu_type;
    logic [DATA_W-1:0]   alu_d1;
    logic [DATA_W-1:0]   alu_d2;
    logic [DATA_W-1:0]   alu_data_out;
    logic [ADDR_W-1:0]   alu_dest_out;
    logic                alu_valid_out;

    logic                wb_valid;
    logic                wb_ready;
    logic [DATA_W-1:0]   wb_data;
    logic [ADDR_W-1:0]   wb_dest;
    logic                wb_lane;

    modport master (
        output req_valid, req_dest, req_op, req_type, req_d1, req_d2,
        output alu_data_out, alu_dest_out, alu_valid_out, wb_ready,
        input  req_ready, alu_call, alu_dest, alu_op, alu_type, alu_d1, alu_d2,
        input  wb_valid, wb_data, wb_dest, wb_lane
    );

    modport slave (
        input  req_valid, req_dest, req_op, req_type, req_d1, req_d2,
        input  alu_data_out, alu_dest_out, alu_valid_out, wb_ready,
        output req_ready, alu_call, alu_dest, alu_op, alu_type, alu_d1, alu_d2,
        output wb_valid, wb_data, wb_dest, wb_lane
    );
endinterface

// File: rtl/alu_issue_sched.sv
// Round-robin sharing of one execute-stage ALU between two issue lanes, with a registered
// result presented to writeback over a valid/ready handshake.
module alu_issue_sched #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int OP_W    = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_issue_sched_if.slave   bus,
    output logic [COUNT_W-1:0] issue_count
);

    logic [ADDR_W-1:0]  lane_dest [2];
    logic [OP_W-1:0]    lane_op   [2];
    logic               lane_type [2];
    logic [DATA_W-1:0]  lane_d1   [2];
    logic [DATA_W-1:0]  lane_d2   [2];

    logic [1:0]         grant;
    logic               grant_lane;
    logic               can_issue;
    logic               issue;

    logic               rr_ptr;
    logic               wb_valid_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic [ADDR_W-1:0]  wb_dest_q;
    logic               wb_lane_q;
    logic [COUNT_W-1:0] count_q;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane_dest[i] = bus.req_dest[i*ADDR_W +: ADDR_W];
            lane_op[i]   = bus.req_op[i*OP_W +: OP_W];
            lane_type[i] = bus.req_type[i];
            lane_d1[i]   = bus.req_d1[i*DATA_W +: DATA_W];
            lane_d2[i]   = bus.req_d2[i*DATA_W +: DATA_W];
        end
    end

    // Contention goes to the lane rr_ptr points at; a lone requester always wins.
    always_comb begin
        grant      = 2'b00;
        grant_lane = 1'b0;
        case (bus.req_valid)
            2'b01: begin
                grant      = 2'b01;
                grant_lane = 1'b0;
            end
            2'b10: begin
                grant      = 2'b10;
                grant_lane = 1'b1;
            end
            2'b11: begin
                grant      = rr_ptr ? 2'b10 : 2'b01;
                grant_lane = rr_ptr;
            end
            default: begin
                grant      = 2'b00;
                grant_lane = 1'b0;
            end
        endcase
    end

    // rst_n gates acceptance so no lane sees ready while reset is held.
    assign can_issue     = rst_n && !flush && (!wb_valid_q || bus.wb_ready);
    assign issue         = can_issue && (grant != 2'b00);
    assign bus.req_ready = can_issue ? grant : 2'b00;
    assign bus.alu_call  = issue;

    always_comb begin
        bus.alu_dest = '0;
        bus.alu_op   = '0;
        bus.alu_type = 1'b0;
        bus.alu_d1   = '0;
        bus.alu_d2   = '0;
        if (issue) begin
            bus.alu_dest = lane_dest[grant_lane];
            bus.alu_op   = lane_op[grant_lane];
            bus.alu_type = lane_type[grant_lane];
            bus.alu_d1   = lane_d1[grant_lane];
            bus.alu_d2   = lane_d2[grant_lane];
        end
    end

    // An issue refills the result slot even while the previous result drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_dest_q  <= '0;
            wb_lane_q  <= 1'b0;
            rr_ptr     <= 1'b0;
            count_q    <= '0;
        end else if (issue) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= bus.alu_data_out;
            wb_dest_q  <= bus.alu_dest_out;
            wb_lane_q  <= grant_lane;
            rr_ptr     <= ~grant_lane;
            count_q    <= count_q + COUNT_W'(1);
        end else if (flush || bus.wb_ready) begin
            wb_valid_q <= 1'b0;
        end
    end

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_dest  = wb_dest_q;
    assign bus.wb_lane  = wb_lane_q;
    assign issue_count  = count_q;

    a_alu_valid_tracks_call: assert property (
        @(posedge clk) disable iff (!rst_n) bus.alu_call |-> bus.alu_valid_out);

    a_ready_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));

    a_wb_stall_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (wb_valid_q && !bus.wb_ready && !flush) |=>
        (wb_valid_q && $stable(wb_data_q) && $stable(wb_dest_q) && $stable(wb_lane_q)));

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched: a behavioural ALU answers the scheduler, and a
// scoreboard queue pairs every accepted request with the writeback result it should produce.
module tb_alu_issue_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [3:0] issue_count;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  l_dest [2];
    logic [3:0]  l_op   [2];
    logic        l_type [2];
    logic [15:0] l_d1   [2];
    logic [15:0] l_d2   [2];

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dest;
        logic        lane;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    alu_issue_sched_if #(.DATA_W(16), .ADDR_W(4), .OP_W(4)) bus ();

    alu_issue_sched #(
        .DATA_W(16), .ADDR_W(4), .OP_W(4), .COUNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    assign bus.req_dest = {l_dest[1], l_dest[0]};
    assign bus.req_op   = {l_op[1], l_op[0]};
    assign bus.req_type = {l_type[1], l_type[0]};
    assign bus.req_d1   = {l_d1[1], l_d1[0]};
    assign bus.req_d2   = {l_d2[1], l_d2[0]};

    // Value ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR. Condition ops: 7 EQC, F NEC.
    function automatic logic [15:0] alu_ref(input logic typ, input logic [3:0] op,
                                            input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = 16'h0000;
        if (!typ) begin
            case (op)
                4'h0: r = a + b;
                4'h1: r = a - b;
                4'h2: r = a & b;
                4'h3: r = a | b;
                4'h4: r = a ^ b;
                default: r = 16'h0000;
            endcase
        end else begin
            case (op)
                4'h7: r = {15'd0, a == b};
                4'hF: r = {15'd0, a != b};
                default: r = 16'h0000;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        bus.alu_data_out  = alu_ref(bus.alu_type, bus.alu_op, bus.alu_d1, bus.alu_d2);
        bus.alu_dest_out  = bus.alu_dest;
        bus.alu_valid_out = bus.alu_call;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int lane, input logic [3:0] dest, input logic [3:0] op,
                                 input logic typ, input logic [15:0] d1, input logic [15:0] d2);
        l_dest[lane] = dest;
        l_op[lane]   = op;
        l_type[lane] = typ;
        l_d1[lane]   = d1;
        l_d2[lane]   = d2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop before push: a result leaving this cycle was accepted in an earlier cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wb_valid && bus.wb_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("sb_data", bus.wb_data, mon_e.data);
                    checkOutput("sb_dest", bus.wb_dest, mon_e.dest);
                    checkOutput("sb_lane", bus.wb_lane, mon_e.lane);
                end
            end else if (bus.wb_valid && flush && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            for (int l = 0; l < 2; l++) begin
                if (bus.req_valid[l] && bus.req_ready[l])
                    sb.push_back('{alu_ref(l_type[l], l_op[l], l_d1[l], l_d2[l]), l_dest[l], l[0]});
            end
        end
    end

    initial begin
        $display("[TB] alu_issue_sched directed run");
        rst_n         = 1'b1;
        flush         = 1'b0;
        bus.req_valid = 2'b00;
        bus.wb_ready  = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(i, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0);
        #1 rst_n = 1'b0;
        tick();
        tick();

        bus.req_valid = 2'b11;
        @(negedge clk);
        checkOutput("rst_req_ready", bus.req_ready, 32'd0);
        checkOutput("rst_alu_call", bus.alu_call, 32'd0);
        checkOutput("rst_wb_valid", bus.wb_valid, 32'd0);
        checkOutput("rst_wb_data", bus.wb_data, 32'd0);
        checkOutput("rst_wb_dest", bus.wb_dest, 32'd0);
        checkOutput("rst_wb_lane", bus.wb_lane, 32'd0);
        checkOutput("rst_issue_count", issue_count, 32'd0);
        tick();
        rst_n = 1'b1;

        applyStimulus(0, 4'd1, 4'h0, 1'b0, 16'h0010, 16'h0001);
        applyStimulus(1, 4'd2, 4'h1, 1'b0, 16'h0020, 16'h0001);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_grant%0d", i), bus.req_ready, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        bus.req_valid = 2'b00;
        checkOutput("rr_issue_count", issue_count, 32'd4);
        checkOutput("rr_last_lane", bus.wb_lane, 32'd1);
        checkOutput("rr_last_data", bus.wb_data, 32'h001F);

        applyStimulus(0, 4'd5, 4'h0, 1'b0, 16'h0003, 16'h0004);
        bus.req_valid = 2'b01;
        @(negedge clk);
        checkOutput("add_req_ready", bus.req_ready, 32'd1);
        checkOutput("add_alu_call", bus.alu_call, 32'd1);
        checkOutput("add_alu_d2", bus.alu_d2, 32'h0004);
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("add_wb_valid", bus.wb_valid, 32'd1);
        checkOutput("add_wb_data", bus.wb_data, 32'h0007);
        checkOutput("add_wb_dest", bus.wb_dest, 32'd5);
        checkOutput("add_wb_lane", bus.wb_lane, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("add_drained", bus.wb_valid, 32'd0);
        tick();

        applyStimulus(1, 4'd9, 4'h1, 1'b0, 16'h0000, 16'h0001);
        bus.req_valid = 2'b10;
        bus.wb_ready  = 1'b0;
        @(negedge clk);
        checkOutput("sub_req_ready", bus.req_ready, 32'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d_ready", i), bus.req_ready, 32'd0);
            checkOutput($sformatf("stall%0d_valid", i), bus.wb_valid, 32'd1);
            checkOutput($sformatf("stall%0d_data", i), bus.wb_data, 32'hFFFF);
            tick();
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        checkOutput("sub_b2b_ready", bus.req_ready, 32'd2);
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("sub_b2b_valid", bus.wb_valid, 32'd1);
        checkOutput("sub_b2b_count", issue_count, 32'd7);
        tick();

        applyStimulus(0, 4'd3, 4'h2, 1'b0, 16'hFF00, 16'h0F0F);
        bus.req_valid = 2'b01;
        bus.wb_ready  = 1'b0;
        @(negedge clk);
        tick();
        applyStimulus(1, 4'd6, 4'h3, 1'b0, 16'h00F0, 16'h0F00);
        flush         = 1'b1;
        bus.req_valid = 2'b11;
        @(negedge clk);
        checkOutput("flush_req_ready", bus.req_ready, 32'd0);
        checkOutput("flush_alu_call", bus.alu_call, 32'd0);
        checkOutput("flush_alu_d1", bus.alu_d1, 32'd0);
        checkOutput("flush_held_data", bus.wb_data, 32'h0F00);
        tick();
        flush         = 1'b0;
        bus.req_valid = 2'b00;
        bus.wb_ready  = 1'b1;
        @(negedge clk);
        checkOutput("flush_wb_valid", bus.wb_valid, 32'd0);
        checkOutput("flush_count", issue_count, 32'd8);
        tick();
        bus.req_valid = 2'b11;
        @(negedge clk);
        checkOutput("flush_rr_kept", bus.req_ready, 32'd2);
        tick();
        bus.req_valid = 2'b00;

        applyStimulus(0, 4'd4, 4'h7, 1'b1, 16'h1234, 16'h1234);
        bus.req_valid = 2'b01;
        @(negedge clk);
        tick();
        applyStimulus(0, 4'd4, 4'hF, 1'b1, 16'h1234, 16'h1234);
        @(negedge clk);
        checkOutput("eqc_wb_data", bus.wb_data, 32'h0001);
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("nec_wb_valid", bus.wb_valid, 32'd1);
        checkOutput("nec_wb_data", bus.wb_data, 32'h0000);
        tick();

        bus.req_valid = 2'b01;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 4'(i), 4'h4, 1'b0, 16'(i), 16'h5555);
            @(negedge clk);
            tick();
        end
        checkOutput("wrap_count", issue_count, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_wb_valid", bus.wb_valid, 32'd0);
        checkOutput("midrst_req_ready", bus.req_ready, 32'd0);
        checkOutput("midrst_alu_call", bus.alu_call, 32'd0);
        checkOutput("midrst_count", issue_count, 32'd0);
        sb.delete();
        applyStimulus(1, 4'd8, 4'h0, 1'b0, 16'h0100, 16'h0001);
        bus.req_valid = 2'b11;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_grant", bus.req_ready, 32'd1);
        tick();
        bus.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("rel_wb_valid", bus.wb_valid, 32'd1);
        checkOutput("rel_wb_lane", bus.wb_lane, 32'd0);
        tick();
        tick();
        checkOutput("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
